// File: rtl/bit_stream_deserializer.sv
// Packs a serial bit stream LSB-first into WORD_WIDTH-bit words and writes them to a result RAM.
// Optional `DESER_CHECKSUM_EN adds a running XOR checksum of every word written in the message.
module bit_stream_deserializer #(
  parameter int WORD_WIDTH = 32,
  parameter int TOTAL_BITS = 256,
  localparam int NUM_WORDS = (TOTAL_BITS + WORD_WIDTH - 1) / WORD_WIDTH,
  localparam int ADDR_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic                  in_bit,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
`ifdef DESER_CHECKSUM_EN
  output logic [WORD_WIDTH-1:0] checksum,
`endif
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
  localparam int IDX_W = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      bitCnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [WORD_WIDTH-1:0] shift_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wrEn_q;
  logic [ADDR_WIDTH-1:0] wrAddr_q;
  logic [WORD_WIDTH-1:0] wrData_q;
  logic                  done_q;
  logic [WORD_WIDTH-1:0] checksum_q;

  logic [WORD_WIDTH-1:0] word_d;
  logic                  lastBit_d;
  logic                  wordFull_d;

  always_comb begin
    word_d     = shift_q | ({{(WORD_WIDTH-1){1'b0}}, in_bit} << idx_q);
    lastBit_d  = (bitCnt_q == LAST_BIT);
    wordFull_d = (idx_q == LAST_IDX);
  end

  // Both final-bit cases schedule their write on the accepting edge; FLUSH is the cycle
  // that write sits on the bus, so done always lands two cycles after the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      wrEn_q     <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      done_q     <= 1'b0;
      checksum_q <= '0;
    end else begin
      wrEn_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= COLLECT;
            bitCnt_q   <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            checksum_q <= '0;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            if (lastBit_d || wordFull_d) begin
              wrEn_q     <= 1'b1;
              wrData_q   <= word_d;
              wrAddr_q   <= addr_q;
              shift_q    <= '0;
              idx_q      <= '0;
              checksum_q <= checksum_q ^ word_d;
            end else begin
              shift_q <= word_d;
              idx_q   <= idx_q + 1'b1;
            end
            if (lastBit_d) begin
              state_q <= FLUSH;
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
              if (wordFull_d) addr_q <= addr_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wr_en   = wrEn_q;
  assign wr_addr = wrAddr_q;
  assign wr_data = wrData_q;
  assign done    = done_q;
  assign busy    = (state_q == COLLECT) || (state_q == FLUSH);

`ifdef DESER_CHECKSUM_EN
  assign checksum = checksum_q;
`else
  logic unusedChecksum;
  assign unusedChecksum = ^checksum_q;
`endif

endmodule
